// File: rtl/main_core.sv
// main_core: streams one data set from a fixed internal ROM and reports its sum and maximum.
module main_core #(
    parameter int unsigned W        = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned NUM_SETS = 3,
    parameter int unsigned IDX_W    = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [IDX_W-1:0]              file_index,
    output logic                          finish,
    output logic [W+$clog2(DEPTH)-1:0]    sum,
    output logic [W-1:0]                  max_val,
    output logic                          error
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = W + AW;

    // FLUSH is the one-cycle hand-off between the last accumulated word and finish.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [W-1:0]      max_q, max_d;
    logic              err_q, err_d;
    logic              fin_q, fin_d;

    logic [W-1:0]      word_c;
    logic              idx_ok_c;

    // ROM word j of set i is (i*DEPTH + j) mod 2^W.
    assign word_c   = W'((32'(idx_q) * 32'(DEPTH)) + 32'(addr_q));
    assign idx_ok_c = 32'(file_index) < 32'(NUM_SETS);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            err_q   <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            err_q   <= err_d;
            fin_q   <= fin_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        max_d   = max_q;
        err_d   = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sum_d  = '0;
                    max_d  = '0;
                    addr_d = '0;
                    if (idx_ok_c) begin
                        idx_d   = file_index;
                        err_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = FLUSH;
                    end
                end
            end
            RUN: begin
                sum_d  = sum_q + SW'(word_c);
                if (word_c > max_q) begin
                    max_d = word_c;
                end
                addr_d = addr_q + AW'(1);
                if (addr_q == AW'(DEPTH - 1)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fin_d = (state_d == DONE);
    end

    assign finish  = fin_q;
    assign sum     = sum_q;
    assign max_val = max_q;
    assign error   = err_q;

endmodule

// File: tb/tb_main_core.sv
// tb_main_core: randomized jobs against a set-level sum/max reference model.
module tb_main_core;

    localparam int unsigned W        = 8;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned NUM_SETS = 3;
    localparam int unsigned IDX_W    = 10;
    localparam int unsigned SW       = W + $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [IDX_W-1:0]  file_index = '0;
    logic              finish;
    logic [SW-1:0]     sum;
    logic [W-1:0]      max_val;
    logic              error;

    int num_checks = 0;
    int num_errors = 0;

    always #5 clk = ~clk;

    main_core #(
        .W(W), .DEPTH(DEPTH), .NUM_SETS(NUM_SETS), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .file_index(file_index),
        .finish(finish), .sum(sum), .max_val(max_val), .error(error)
    );

    // Compare one observed value with its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: sum of all words of a set (0 for an invalid set).
    function automatic int unsigned ref_sum(input int unsigned idx);
        int unsigned s = 0;
        if (idx >= NUM_SETS) return 0;
        for (int j = 0; j < int'(DEPTH); j++) s += (idx * DEPTH + j) % (1 << W);
        return s;
    endfunction

    // Reference: largest word of a set (0 for an invalid set).
    function automatic int unsigned ref_max(input int unsigned idx);
        int unsigned m = 0;
        if (idx >= NUM_SETS) return 0;
        for (int j = 0; j < int'(DEPTH); j++)
            if ((idx * DEPTH + j) % (1 << W) > m) m = (idx * DEPTH + j) % (1 << W);
        return m;
    endfunction

    // Launch one job, hold start for 'hold' samples, check latency and results.
    task automatic run_job(input int unsigned idx, input int hold, input string tag);
        int exp_lat;
        int got_lat;
        int h;
        exp_lat = (idx < NUM_SETS) ? int'(DEPTH) + 1 : 1;
        h = (hold > exp_lat) ? exp_lat : hold;
        @(negedge clk);
        start = 1'b1;
        file_index = IDX_W'(idx);
        @(posedge clk);
        #1;
        check({tag, "_drop"}, 32'(finish), 32'd0);
        got_lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n >= h) start = 1'b0;
            @(posedge clk);
            #1;
            if (finish) begin
                got_lat = n;
                break;
            end
        end
        check({tag, "_lat"}, 32'(got_lat), 32'(exp_lat));
        check({tag, "_sum"}, 32'(sum), ref_sum(idx));
        check({tag, "_max"}, 32'(max_val), ref_max(idx));
        check({tag, "_err"}, 32'(error), (idx >= NUM_SETS) ? 32'd1 : 32'd0);
    endtask

    // Idle in DONE for a few cycles, results must hold.
    task automatic hold_done(input int unsigned idx, input int cycles, input string tag);
        for (int g = 0; g < cycles; g++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_fin"}, 32'(finish), 32'd1);
            check({tag, "_hold_sum"}, 32'(sum), ref_sum(idx));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned idx;
        int got;
        // Reset values
        #12;
        check("rst_fin", 32'(finish), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_max", 32'(max_val), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed jobs: sets 0,1,2, invalid index, recovery
        run_job(0, 2, "set0");
        check("set0_abs_sum", 32'(sum), 32'd120);
        run_job(1, 2, "set1");
        check("set1_abs_sum", 32'(sum), 32'd376);
        run_job(2, 1, "set2");
        check("set2_abs_max", 32'(max_val), 32'd47);
        run_job(5, 1, "bad5");
        hold_done(5, 2, "bad5");
        run_job(0, 1, "recover");

        // Reset in the middle of RUN
        @(negedge clk);
        start = 1'b1;
        file_index = IDX_W'(0);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_fin", 32'(finish), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_max", 32'(max_val), 32'd0);
        check("midrst_err", 32'(error), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("midrst_idle", 32'(finish), 32'd0);
        end
        run_job(1, 1, "postrst");

        // Start held high: one-cycle finish pulses, DEPTH+1 cycles low between
        @(negedge clk);
        start = 1'b1;
        file_index = IDX_W'(2);
        got = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (finish) begin
                got = n;
                break;
            end
        end
        check("held_first_lat", 32'(got), 32'(DEPTH + 2));
        for (int r = 0; r < 3; r++) begin
            check("held_sum", 32'(sum), ref_sum(2));
            @(posedge clk);
            #1;
            check("held_width", 32'(finish), 32'd0);
            got = 0;
            for (int n = 1; n <= 40; n++) begin
                @(posedge clk);
                #1;
                if (finish) begin
                    got = n;
                    break;
                end
            end
            check("held_gap", 32'(got), 32'(DEPTH + 1));
        end
        @(negedge clk);
        start = 1'b0;
        hold_done(2, 1, "held_end");

        // Randomized jobs, mixed valid/invalid, random hold and idle gaps
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 4) == 0) idx = $urandom_range(NUM_SETS, (1 << IDX_W) - 1);
            else idx = $urandom_range(0, NUM_SETS - 1);
            run_job(idx, int'($urandom_range(1, 4)), "rnd");
            hold_done(idx, int'($urandom_range(0, 3)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/main_core.md
Name: main_core

Overview:
- Top-level processing core. `start` launches one job on the data set selected by `file_index`.
- Data sets live in an internal read-only table of NUM_SETS sets × DEPTH words.
- The core streams the selected set word by word and computes its sum and maximum, then raises `finish`.
- Jobs run back to back under a simple start/finish handshake.

Parameters:
- W, 8, data word width in bits.
- DEPTH, 16, words per data set (power of two, ≥2).
- NUM_SETS, 3, number of valid data sets.
- IDX_W, 10, width of `file_index`.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job request, level-sampled on clk.
- file_index  in  IDX_W  data set select, sampled together with `start`.
- finish  out  1  job complete; held high in DONE.
- sum  out  W+log2(DEPTH)  sum of all words of the selected set.
- max_val  out  W  largest word of the selected set.
- error  out  1  `file_index` was ≥ NUM_SETS for the last job.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - finish, error = 0; sum, max_val = 0; address counter = 0; latched index = 0.
- Table contents are fixed: word j of set i = (i*DEPTH + j) mod 2^W. Implement as combinational ROM or function.
- IDLE:
  - start=1 and file_index < NUM_SETS → latch index, clear sum/max_val/address/error → RUN.
  - start=1 and file_index ≥ NUM_SETS → error=1, sum=0, max_val=0 → DONE.
  - start=0 → stay in IDLE.
- RUN:
  - Each cycle read word[idx][addr].
  - sum += word, zero-extended.
  - max_val = word if word > max_val.
  - addr++.
  - After the word at addr=DEPTH-1 is consumed → DONE.
  - Exactly DEPTH cycles in RUN. `start` is ignored in RUN.
- DONE:
  - finish=1; sum, max_val and error are held stable.
  - start=1 → finish cleared on that edge and a new job starts with the same rules as IDLE (RUN or immediate DONE with error).
- Latency: start sampled at edge k → finish high after edge k+DEPTH+1; error jobs raise finish after edge k+1.
- `start` held high for several cycles still launches exactly one job, because it is ignored in RUN.
- Outputs are registered. sum and max_val are intermediate (not valid) while finish=0.
- sum cannot overflow: its width covers DEPTH·(2^W−1).
- Reset asserted mid-RUN aborts the job immediately and forces all outputs to their reset values.

Test Plan:
1. Reset, then start=1 for 2 cycles with file_index=0 → finish high 17 cycles after the first sampled edge; sum=120, max_val=15, error=0.
2. After finish, start=1 for 2 cycles with file_index=1 → finish drops on the next edge, then rises after 17 cycles; sum=376, max_val=31.
3. Back-to-back job with file_index=2 → sum=632, max_val=47, error=0.
4. file_index=5 → finish after 1 cycle; error=1, sum=0, max_val=0. A following job with file_index=0 clears error and gives sum=120.
5. Assert rst_n=0 during cycle 8 of RUN → finish=0 and sum=0 immediately. After release, state is IDLE and a new index-1 job gives sum=376.
6. Hold start high continuously → jobs repeat; each finish pulse lasts exactly 1 cycle, followed by 16 RUN cycles.
